// File: rtl/adder_vec_pkg.sv
// Shared constants, state encoding and vector-entry field layout for the
// serial-adder vector driver.
package adder_vec_pkg;

  // Default number of vector entries and cycles each vector is held.
  localparam int unsigned N    = 8;
  localparam int unsigned HOLD = 6;

  // Widths of the entry word, entry index and error counter.
  localparam int unsigned EntryW = 7;
  localparam int unsigned AddrW  = 3;
  localparam int unsigned ErrW   = 4;

  // Bit positions inside an entry word {start,rst,B,A,CIN,expS,expCOUT}.
  localparam int unsigned BitStart   = 6;
  localparam int unsigned BitRst     = 5;
  localparam int unsigned BitB       = 4;
  localparam int unsigned BitA       = 3;
  localparam int unsigned BitCin     = 2;
  localparam int unsigned BitExpS    = 1;
  localparam int unsigned BitExpCout = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Expected {S, COUT} response carried in an entry.
  function automatic logic [1:0] exp_bits(input logic [EntryW-1:0] entry);
    return {entry[BitExpS], entry[BitExpCout]};
  endfunction

endpackage

// File: rtl/adder_vec_driver_if.sv
// Bundle of the memory write port, run control, stimulus/response and
// run-status signals between the vector driver and its environment.
interface adder_vec_driver_if;
  import adder_vec_pkg::*;

  logic              wr_en;
  logic [AddrW-1:0]  wr_addr;
  logic [EntryW-1:0] wr_data;
  logic              go;
  logic              start;
  logic              rst;
  logic              B;
  logic              A;
  logic              CIN;
  logic              S;
  logic              COUT;
  logic              busy;
  logic              done;
  logic [ErrW-1:0]   err_cnt;
  logic [AddrW-1:0]  first_fail;

  // Environment side: loads vectors, starts runs, returns adder responses.
  modport master (
    output wr_en, wr_addr, wr_data, go, S, COUT,
    input  start, rst, B, A, CIN, busy, done, err_cnt, first_fail
  );

  // Driver side.
  modport slave (
    input  wr_en, wr_addr, wr_data, go, S, COUT,
    output start, rst, B, A, CIN, busy, done, err_cnt, first_fail
  );

endinterface

// File: rtl/vec_mem.sv
// Depth x Width register file: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module vec_mem #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 7,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adder_vec_driver.sv
// Replays a small table of stimulus vectors into a serial-adder state machine,
// holding each vector for HOLD cycles, sampling {S,COUT} on the last hold cycle
// and counting mismatches against the expected bits stored with each vector.
module adder_vec_driver #(
  parameter int unsigned N    = adder_vec_pkg::N,
  parameter int unsigned HOLD = adder_vec_pkg::HOLD
) (
  input logic               CLK,
  input logic               NRST,
  adder_vec_driver_if.slave bus
);
  import adder_vec_pkg::state_e;
  import adder_vec_pkg::StIdle;
  import adder_vec_pkg::StDrive;
  import adder_vec_pkg::StDone;
  import adder_vec_pkg::EntryW;
  import adder_vec_pkg::AddrW;
  import adder_vec_pkg::ErrW;
  import adder_vec_pkg::BitStart;
  import adder_vec_pkg::BitRst;
  import adder_vec_pkg::BitB;
  import adder_vec_pkg::BitA;
  import adder_vec_pkg::BitCin;
  import adder_vec_pkg::exp_bits;

  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  idx_q, idx_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic [AddrW-1:0]  ff_q, ff_d;
  // Whole entry currently driven; its expected bits are used at the sample edge.
  logic [EntryW-1:0] entry_q, entry_d;

  logic              mem_we;
  logic [AddrW-1:0]  mem_raddr;
  logic [EntryW-1:0] mem_rdata;
  logic [EntryW-1:0] first_entry;
  logic              last_hold;
  logic              last_idx;
  logic              mismatch;
  logic              err_sat;

  // Memory is frozen while a run is in progress.
  assign mem_we = bus.wr_en && (state_q == StIdle);

  // The read port looks one entry ahead so the next vector is ready at the
  // sample edge; in IDLE it points at entry 0 for the run start.
  assign mem_raddr = (state_q == StIdle) ? '0 : idx_q + AddrW'(1);

  // A write to entry 0 in the go cycle must be seen by the run.
  assign first_entry = (mem_we && (bus.wr_addr == '0)) ? bus.wr_data : mem_rdata;

  assign last_hold = (hold_q == HoldW'(HOLD - 1));
  assign last_idx  = (idx_q == AddrW'(N - 1));
  assign mismatch  = ({bus.S, bus.COUT} != exp_bits(entry_q));
  assign err_sat   = (err_q == ErrW'(N));

  vec_mem #(
    .Depth(N),
    .Width(EntryW),
    .AddrW(AddrW)
  ) u_vec_mem (
    .clk_i  (CLK),
    .we_i   (mem_we),
    .waddr_i(bus.wr_addr),
    .wdata_i(bus.wr_data),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  // Next-state, counter and compare logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    ff_d    = ff_q;
    entry_d = entry_q;
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          ff_d    = '0;
          entry_d = first_entry;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (last_hold) begin
          hold_d = '0;
          if (mismatch) begin
            if (!err_sat) begin
              err_d = err_q + ErrW'(1);
            end
            if (err_q == '0) begin
              ff_d = idx_q;
            end
          end
          if (last_idx) begin
            entry_d = '0;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + AddrW'(1);
            entry_d = mem_rdata;
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        entry_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      entry_q <= entry_d;
    end
  end

  // entry_q is zero outside DRIVE, so the stimulus is idle there as well.
  assign bus.start      = entry_q[BitStart];
  assign bus.rst        = entry_q[BitRst];
  assign bus.B          = entry_q[BitB];
  assign bus.A          = entry_q[BitA];
  assign bus.CIN        = entry_q[BitCin];
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.err_cnt    = err_q;
  assign bus.first_fail = ff_q;

endmodule
